// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit
// duration used by both the transmitter and the receiver.
package uart_pkg;

  // 200 MHz clock / 115200 baud
  localparam int unsigned UART_BITDUR = 1736;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// high so an idle line never looks like a start bit coming out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic sin
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // next-state: plain shift chain
  always_comb begin
    s1_d = in;
    s2_d = s1_q;
  end

  // synchronizer flops, reset to the idle level
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign sin = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a valid/ready holding register.
// Optional macro UART_RX_MAJORITY_EN: each bit sample becomes the 2-of-3
// majority of the synchronized line over the sample cycle and the two
// cycles before it, rejecting single-cycle glitches.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BITDUR = UART_BITDUR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frameErr,
  output logic       overrun
);

  localparam int unsigned CTR_W = $clog2(BITDUR);
  localparam int unsigned H     = BITDUR / 2;
  localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(H - 1);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(BITDUR - 1);

  logic sin;
  logic sample;

  rx_state_e        state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [2:0]       i_q, i_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .sin   (sin)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is sin one cycle ago, hist_q[1] two cycles ago
  logic [1:0] hist_q, hist_d;
  logic [2:0] hist;

  // history shift and 2-of-3 vote over {t-2, t-1, t}
  always_comb begin
    hist_d = {hist_q[0], sin};
    hist   = {hist_q, sin};
    sample = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  end

  // history register, reset to the idle level
  always_ff @(posedge clk) begin
    if (reset) hist_q <= '1;
    else       hist_q <= hist_d;
  end
`else
  assign sample = sin;
`endif

  // frame FSM next-state plus holding-register update
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    i_d     = i_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    // consumption happens first; a completing byte below overrides it
    if (valid_q && ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!sin) begin
          state_d = START;
          ctr_d   = '0;
        end
      end
      START: begin
        if (ctr_q == CTR_HALF) begin
          if (!sample) begin
            state_d = DATA;
            ctr_d   = '0;
            i_d     = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      DATA: begin
        if (ctr_q == CTR_LAST) begin
          shreg_d[i_q] = sample;
          ctr_d        = '0;
          if (i_q == 3'd7) state_d = STOP;
          else             i_d     = i_q + 3'd1;
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      STOP: begin
        if (ctr_q == CTR_LAST) begin
          ctr_d = '0;
          if (sample) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            ov_d    = valid_q && !ready;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BRK;
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      BRK: begin
        if (sin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      i_q     <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      i_q     <= i_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign busy     = (state_q != IDLE);
  assign frameErr = fe_q;
  assign overrun  = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BITDUR=16 (H=8). Inputs change on the
// falling edge, outputs are checked on the falling edge or #1 after a rise.
module tb_uart_rx;

  localparam int unsigned BD = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, busy, frameErr, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx #(.BITDUR(BD)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy),
    .frameErr (frameErr),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (frameErr) fe_cnt++;
    if (overrun)  ov_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame starting at the current negedge; stop bit value is
  // selectable, the line is then held at hold_lvl for hold cycles before
  // going back high. glitch inverts the line for one cycle at the centre of
  // every data bit.
  task automatic send(input logic [7:0] b, input logic stopb, input bit glitch,
                      input int hold, input logic hold_lvl);
    logic [9:0] bits;
    bits = {stopb, b, 1'b0};
    for (int c = 0; c < 10 * BD; c++) begin
      in = bits[c / BD];
      if (glitch && (c % BD == 8) && (c / BD >= 1) && (c / BD <= 8)) in = ~in;
      @(negedge clk);
    end
    in = hold_lvl;
    repeat (hold) @(negedge clk);
    in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic consume();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("valid_after_ready", int'(valid), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stopb;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'hFF, 1};   // bad stop: data keeps 0xFF
    vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};

    do_reset();
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fe", int'(frameErr), 0);
    check("rst_ov", int'(overrun), 0);

    // exact latency: in falls at negedge N, sin=0 two rises later (t0),
    // valid registers at t0+153, i.e. right after the 155th rise
    fork
      send(8'hA5, 1'b1, 1'b0, 0, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 check("lat_valid_early", int'(valid), 0);
        @(posedge clk);
        #1 check("lat_valid", int'(valid), 1);
        check("lat_data", int'(data), 8'hA5);
      end
    join
    check("lat_fe", fe_cnt, 0);
    check("lat_ov", ov_cnt, 0);
    consume();

    // table of single frames, each consumed afterwards
    for (int v = 0; v < 5; v++) begin
      fe_cnt = 0;
      ov_cnt = 0;
      send(vecs[v].b, vecs[v].stopb, 1'b0, 0, 1'b1);
      check($sformatf("vec%0d_valid", v), int'(valid), int'(vecs[v].exp_valid));
      check($sformatf("vec%0d_data", v), int'(data), int'(vecs[v].exp_data));
      check($sformatf("vec%0d_fe", v), fe_cnt, vecs[v].exp_fe);
      check($sformatf("vec%0d_ov", v), ov_cnt, 0);
      check($sformatf("vec%0d_busy", v), int'(busy), 0);
      if (vecs[v].exp_valid) consume();
    end

    // false start: 4 low cycles; busy from t0+1 to t0+8, clear at t0+9
    fe_cnt = 0;
    fork
      begin
        in = 1'b0;
        repeat (4) @(negedge clk);
        in = 1'b1;
      end
      begin
        repeat (3) @(posedge clk);
        #1 check("fs_busy_t1", int'(busy), 1);
        repeat (7) @(posedge clk);
        #1 check("fs_busy_t8", int'(busy), 1);
        @(posedge clk);
        #1 check("fs_busy_t9", int'(busy), 0);
      end
    join
    repeat (30) @(negedge clk);
    check("fs_valid", int'(valid), 0);
    check("fs_fe", fe_cnt, 0);
    send(8'h3C, 1'b1, 1'b0, 0, 1'b1);
    check("fs_next_valid", int'(valid), 1);
    check("fs_next_data", int'(data), 8'h3C);
    consume();

    // break: bad stop then line low 40 more cycles
    fe_cnt = 0;
    fork
      send(8'h3C, 1'b0, 1'b0, 40, 1'b0);
      begin
        repeat (10 * BD + 30) @(negedge clk);
        check("brk_busy_held", int'(busy), 1);
        check("brk_valid_held", int'(valid), 0);
      end
    join
    check("brk_fe_once", fe_cnt, 1);
    check("brk_valid", int'(valid), 0);
    check("brk_busy_end", int'(busy), 0);

    // overrun: two frames, never consumed
    ov_cnt = 0;
    send(8'h11, 1'b1, 1'b0, 0, 1'b1);
    check("ov_first_ov", ov_cnt, 0);
    send(8'h22, 1'b1, 1'b0, 0, 1'b1);
    check("ov_valid", int'(valid), 1);
    check("ov_data", int'(data), 8'h22);
    check("ov_pulse", ov_cnt, 1);
    consume();

    // ready lands exactly in the completion cycle of 0x22
    send(8'h11, 1'b1, 1'b0, 0, 1'b1);
    ov_cnt = 0;
    fork
      send(8'h22, 1'b1, 1'b0, 0, 1'b1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("hs_valid_kept", int'(valid), 1);
        check("hs_data", int'(data), 8'h22);
      end
    join
    check("hs_no_ov", ov_cnt, 0);
    check("hs_valid_end", int'(valid), 1);
    consume();

    // reset in the middle of DATA with a byte pending
    send(8'h11, 1'b1, 1'b0, 0, 1'b1);
    fork
      send(8'hFF, 1'b1, 1'b0, 0, 1'b1);
      begin
        repeat (60) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mr_valid", int'(valid), 0);
        check("mr_data", int'(data), 0);
        check("mr_busy", int'(busy), 0);
        check("mr_fe", int'(frameErr), 0);
        check("mr_ov", int'(overrun), 0);
        @(negedge clk);
        reset = 1'b0;
      end
    join
    check("mr_no_valid", int'(valid), 0);
    send(8'h5A, 1'b1, 1'b0, 0, 1'b1);
    check("mr_next_valid", int'(valid), 1);
    check("mr_next_data", int'(data), 8'h5A);
    consume();

`ifdef UART_RX_MAJORITY_EN
    // single-cycle glitch at every data sample point must be voted out
    fe_cnt = 0;
    send(8'h5A, 1'b1, 1'b1, 0, 1'b1);
    check("maj_valid", int'(valid), 1);
    check("maj_data", int'(data), 8'h5A);
    check("maj_fe", fe_cnt, 0);
    consume();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
